vec_mem_sequencer: RTL and testbench
====================================

# vec_mem_sequencer

Multi-beat memory access sequencer between the Memory stage of the SIMD pipeline and the data memory port. A vector load or store (VecData) moves one VEC_W-bit register as VEC_W/BUS_W consecutive bus beats; a scalar access (MemData) moves one beat. The block stalls the pipeline until the transfer completes, then presents the assembled load data.

## Interface
Parameters:
- VEC_W, 128, vector register width in bits
- BUS_W, 32, memory data bus width in bits; VEC_W must be an integer multiple of BUS_W
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  Memory-stage access request (level); sampled only in IDLE
- we  in  1  1 = store, 0 = load
- vec  in  1  1 = vector access (NBEAT beats), 0 = scalar (1 beat)
- addr  in  ADDR_W  base byte address
- wdata  in  VEC_W  store data; scalar stores use wdata[BUS_W-1:0]
- stall  out  1  hold the pipeline stages up to and including Memory
- done  out  1  one-cycle pulse: transfer complete, rdata valid
- rdata  out  VEC_W  assembled load data
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat write enable
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  BUS_W  beat write data
- mem_rdata  in  BUS_W  beat read data, valid with mem_ack
- mem_ack  in  1  beat accepted/completed this cycle

## Operation
- NBEAT = VEC_W/BUS_W; BSTEP = BUS_W/8 bytes.
- States: IDLE, XFER, DONE.
- IDLE: if start, latch we, vec, addr (low log2(BSTEP) bits forced to 0), wdata; clear beat counter and rdata; last = vec ? NBEAT-1 : 0. Next state XFER.
- XFER: mem_req=1, mem_we=latched we, mem_addr = base + beat*BSTEP (modulo 2^ADDR_W, wrap allowed), mem_wdata = wdata_l[beat*BUS_W +: BUS_W].
  - On mem_ack: for loads, rdata[beat*BUS_W +: BUS_W] <= mem_rdata; if beat == last, go to DONE, else beat+1 and stay in XFER.
  - Without mem_ack: hold all mem_* outputs stable.
- DONE: done=1, mem_req=0; next state IDLE unconditionally. start in DONE is ignored; it belongs to the instruction just finishing.
- Scalar load: rdata upper VEC_W-BUS_W bits are zero.
- Stores: rdata is left at 0.
- mem_ack outside XFER is ignored.
- stall = (state==IDLE && start) || state==XFER. Combinational, so the requesting instruction is held from its first cycle in the Memory stage.
- Reset (any state, including mid-transfer): state IDLE, beat counter 0, rdata 0. All outputs 0: stall only follows start, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. A partially issued transfer is abandoned.

## Timing
- All state, counter, rdata and mem_* outputs are registered. mem_* change only on the clock edge that enters XFER or consumes an ack.
- The only combinational output is stall.
- Latency with mem_ack held high, start seen in cycle 0:
  - vector: XFER in cycles 1..4 (NBEAT=4), done and valid rdata in cycle 5, stall low in cycle 5.
  - scalar: XFER in cycle 1, done in cycle 2.
- Each cycle of mem_ack low in XFER adds one cycle.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE. Minimum request spacing is NBEAT+2 cycles (vector) or 3 cycles (scalar).
- rdata holds its value after DONE until the next start is accepted in IDLE.

## Test plan
- Vector load: addr=0x100, mem_ack always 1, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem_addr 0x100, 0x104, 0x108, 0x10C; done in cycle 5; rdata=0x44444444_33333333_22222222_11111111; stall high in cycles 0-4.
- Vector store with wait states: wdata=0xDDDD..._AAAA... (beat k = pattern k), ack low 2 cycles before each beat -> mem_wdata/mem_addr stable while waiting, beats in order 0..3, done at cycle 13.
- Scalar load: addr=0x203 -> mem_addr=0x200, single beat, done at cycle 2, rdata upper 96 bits 0.
- Wrap: vector load at addr=0xFFFFFFF8 -> mem_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Start held high across two instructions: second request begins XFER 1 cycle after DONE; stray mem_ack in IDLE/DONE -> no rdata change.
- Async reset asserted in XFER after beat 1 -> mem_req, done, rdata, mem_addr are 0 immediately; after release with start=0, stays IDLE and stall=0.

Source files
------------

// File: rtl/vec_mem_sequencer_if.sv
// Memory-port bundle between the vector memory sequencer and the data memory.
//   master (sequencer): drives mem_req, mem_we, mem_addr, mem_wdata;
//                       receives mem_rdata, mem_ack.
//   slave  (memory)   : the reverse.
// Handshake: a beat is transferred in every cycle where mem_req and mem_ack
// are both high. While mem_req is high and mem_ack is low, the master keeps
// mem_we/mem_addr/mem_wdata unchanged. mem_rdata is valid only with mem_ack.
// mem_ack without mem_req is ignored by the master.
interface vec_mem_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic [BUS_W-1:0]  mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Multi-beat memory access sequencer for the SIMD Memory stage.
// A vector access moves VEC_W bits as NBEAT = VEC_W/BUS_W bus beats at
// consecutive BUS_W/8-byte addresses; a scalar access moves one beat.
// The pipeline is stalled until the transfer completes, then done pulses
// for one cycle with the assembled load data on rdata.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start      : access request level, sampled only in IDLE
//   we, vec    : 1 = store / 1 = vector (NBEAT beats)
//   addr       : base byte address (forced to bus alignment)
//   wdata      : store data, scalar stores use the low BUS_W bits
//   stall      : combinational pipeline hold
//   done       : one-cycle completion pulse, rdata valid
//   rdata      : assembled load data, held until the next accepted start
//   state_dbg  : current FSM state (0 IDLE, 1 XFER, 2 DONE)
//   mem        : memory port (master side)
module vec_mem_sequencer #(
    parameter int VEC_W  = 128,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic              vec,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VEC_W-1:0]  wdata,
    output logic              stall,
    output logic              done,
    output logic [VEC_W-1:0]  rdata,
    output logic [1:0]        state_dbg,
    vec_mem_sequencer_if.master mem
);
    localparam int NBEAT = VEC_W / BUS_W;
    localparam int BSTEP = BUS_W / 8;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    localparam logic [BW-1:0]     LAST_VEC = BW'(NBEAT - 1);
    localparam logic [ADDR_W-1:0] AMASK    = ~ADDR_W'(BSTEP - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [BW-1:0]    beat;
    logic [BW-1:0]    last;
    logic             we_l;
    logic [VEC_W-1:0] wdata_l;
    logic [BW:0]      beat_nx;

    // One bit wider than beat so the increment past the last beat cannot
    // wrap; the value is only used when another beat follows.
    always_comb begin
        beat_nx = {1'b0, beat} + (BW + 1)'(1);
    end

    always_comb begin
        stall     = (state == IDLE && start) || (state == XFER);
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            last          <= '0;
            we_l          <= 1'b0;
            wdata_l       <= '0;
            rdata         <= '0;
            done          <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= XFER;
                        we_l          <= we;
                        beat          <= '0;
                        last          <= vec ? LAST_VEC : '0;
                        wdata_l       <= wdata;
                        rdata         <= '0;
                        // First beat is presented straight from the inputs
                        // so the memory sees it in the first XFER cycle.
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= we;
                        mem.mem_addr  <= addr & AMASK;
                        mem.mem_wdata <= wdata[BUS_W-1:0];
                    end
                end
                XFER: begin
                    if (mem.mem_ack) begin
                        if (!we_l) begin
                            rdata[beat*BUS_W +: BUS_W] <= mem.mem_rdata;
                        end
                        if (beat == last) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                        end else begin
                            beat          <= beat + BW'(1);
                            // Address wraps modulo 2^ADDR_W by design.
                            mem.mem_addr  <= mem.mem_addr + ADDR_W'(BSTEP);
                            mem.mem_wdata <= wdata_l[beat_nx*BUS_W +: BUS_W];
                        end
                    end
                end
                DONE: begin
                    // start seen here belongs to the finishing instruction.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;

    logic         clk;
    logic         rst;
    logic         start;
    logic         we;
    logic         vec;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         stall;
    logic         done;
    logic [127:0] rdata;
    logic [1:0]   state_dbg;

    int tests;
    int fails;

    vec_mem_sequencer_if #(.ADDR_W(32), .BUS_W(32)) mem ();

    vec_mem_sequencer #(.VEC_W(128), .BUS_W(32), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .we        (we),
        .vec       (vec),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .state_dbg (state_dbg),
        .mem       (mem.master)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic            vec;
        logic [31:0]     addr;
        logic [127:0]    wdata;
        int              waits;
        logic [3:0][31:0] rd;
        logic [3:0][31:0] exp_addr;
        int              exp_nbeat;
        int              exp_done;
        logic [127:0]    exp_rdata;
    } rec_t;

    rec_t recs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input int i, input logic w, input logic v, input logic [31:0] a,
                           input logic [127:0] wd, input int wt, input logic [127:0] rd,
                           input logic [127:0] ea, input int nb, input int dc,
                           input logic [127:0] er);
        recs[i].we = w;
        recs[i].vec = v;
        recs[i].addr = a;
        recs[i].wdata = wd;
        recs[i].waits = wt;
        recs[i].rd = rd;
        recs[i].exp_addr = ea;
        recs[i].exp_nbeat = nb;
        recs[i].exp_done = dc;
        recs[i].exp_rdata = er;
    endtask

    // Driver: starts in an IDLE cycle at posedge+1, plays memory with the
    // record's wait states, ends in the IDLE cycle after done.
    task automatic run_rec(input int idx);
        rec_t r;
        int beat;
        int wcnt;
        int done_c;
        logic stall_ok;
        r = recs[idx];
        beat = 0;
        wcnt = 0;
        done_c = -1;
        stall_ok = 1'b1;
        start = 1'b1;
        we = r.we;
        vec = r.vec;
        addr = r.addr;
        wdata = r.wdata;
        mem.mem_ack = 1'b0;
        #1;
        chk($sformatf("rec%0d idle_state", idx), 128'(state_dbg), 128'(S_IDLE));
        for (int c = 0; c < 60; c++) begin
            if (mem.mem_req) begin
                if (beat < r.exp_nbeat) begin
                    chk($sformatf("rec%0d c%0d mem_addr", idx, c), 128'(mem.mem_addr), 128'(r.exp_addr[beat]));
                    chk($sformatf("rec%0d c%0d mem_we", idx, c), 128'(mem.mem_we), 128'(r.we));
                    if (r.we)
                        chk($sformatf("rec%0d c%0d mem_wdata", idx, c), 128'(mem.mem_wdata),
                            128'(r.wdata[beat*32 +: 32]));
                end
                if (wcnt < r.waits) begin
                    mem.mem_ack = 1'b0;
                    mem.mem_rdata = 32'hBAD0BAD0;
                    wcnt++;
                end else begin
                    mem.mem_ack = 1'b1;
                    mem.mem_rdata = (beat < 4) ? r.rd[beat] : 32'hBAD0BAD0;
                    beat++;
                    wcnt = 0;
                end
            end else begin
                mem.mem_ack = 1'b0;
            end
            if (done) begin
                done_c = c;
                if (stall) stall_ok = 1'b0;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            if (c == 1) start = 1'b0;
            tick();
        end
        mem.mem_ack = 1'b0;
        start = 1'b0;
        chk($sformatf("rec%0d done_cycle", idx), 128'(done_c), 128'(r.exp_done));
        chk($sformatf("rec%0d beats", idx), 128'(beat), 128'(r.exp_nbeat));
        chk($sformatf("rec%0d rdata", idx), rdata, r.exp_rdata);
        chk($sformatf("rec%0d stall_profile", idx), 128'(stall_ok), 128'(1'b1));
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start = 1'b0;
        we = 1'b0;
        vec = 1'b0;
        addr = '0;
        wdata = '0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;

        #2;
        chk("reset mem_req", 128'(mem.mem_req), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset rdata", rdata, 128'(0));
        chk("reset mem_addr", 128'(mem.mem_addr), 128'(0));
        chk("reset stall", 128'(stall), 128'(0));
        chk("reset state", 128'(state_dbg), 128'(S_IDLE));
        #10;
        rst = 1'b0;
        tick();

        // Scoreboard table: hand-computed addresses, done cycle and rdata.
        set_rec(0, 1'b0, 1'b1, 32'h100, 128'h0, 0,
                128'h44444444_33333333_22222222_11111111,
                128'h0000010C_00000108_00000104_00000100, 4, 5,
                128'h44444444_33333333_22222222_11111111);
        set_rec(1, 1'b1, 1'b1, 32'h400, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2,
                128'h00000009_00000008_00000007_00000006,
                128'h0000040C_00000408_00000404_00000400, 4, 13, 128'h0);
        set_rec(2, 1'b0, 1'b0, 32'h203, 128'h0, 0,
                128'h99999999_88888888_77777777_CAFEF00D,
                128'h0_0_0_00000200, 1, 2, 128'h00000000_00000000_00000000_CAFEF00D);
        set_rec(3, 1'b0, 1'b1, 32'hFFFFFFF8, 128'h0, 0,
                128'h0D0D0D04_0C0C0C03_0B0B0B02_0A0A0A01,
                128'h00000004_00000000_FFFFFFFC_FFFFFFF8, 4, 5,
                128'h0D0D0D04_0C0C0C03_0B0B0B02_0A0A0A01);
        set_rec(4, 1'b1, 1'b0, 32'h507, 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_12345678, 1,
                128'h00000001_00000002_00000003_00000004,
                128'h0_0_0_00000504, 1, 3, 128'h0);
        set_rec(5, 1'b0, 1'b1, 32'h10, 128'h0, 1,
                128'h80000004_70000003_60000002_50000001,
                128'h0000001C_00000018_00000014_00000010, 4, 9,
                128'h80000004_70000003_60000002_50000001);

        for (int i = 0; i < 6; i++) run_rec(i);

        // Back-to-back with start held high, plus stray acks in DONE/IDLE.
        start = 1'b1; we = 1'b0; vec = 1'b0; addr = 32'h40; mem.mem_ack = 1'b0;
        #1;
        chk("b2b c0 stall", 128'(stall), 128'(1));
        tick();  // c1
        chk("b2b c1 mem_req", 128'(mem.mem_req), 128'(1));
        chk("b2b c1 mem_addr", 128'(mem.mem_addr), 128'(32'h40));
        addr = 32'h80;
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hAAAA0001;
        tick();  // c2 DONE
        chk("b2b c2 done", 128'(done), 128'(1));
        chk("b2b c2 rdata", rdata, 128'(32'hAAAA0001));
        chk("b2b c2 mem_req", 128'(mem.mem_req), 128'(0));
        chk("b2b c2 stall", 128'(stall), 128'(0));
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hDEADBEEF;
        tick();  // c3 IDLE
        chk("b2b c3 done", 128'(done), 128'(0));
        chk("b2b c3 mem_req", 128'(mem.mem_req), 128'(0));
        chk("b2b c3 stall", 128'(stall), 128'(1));
        chk("b2b c3 rdata", rdata, 128'(32'hAAAA0001));
        tick();  // c4 XFER of second request
        start = 1'b0;
        chk("b2b c4 mem_req", 128'(mem.mem_req), 128'(1));
        chk("b2b c4 mem_addr", 128'(mem.mem_addr), 128'(32'h80));
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'hBBBB0002;
        tick();  // c5 DONE
        chk("b2b c5 done", 128'(done), 128'(1));
        chk("b2b c5 rdata", rdata, 128'(32'hBBBB0002));
        mem.mem_ack = 1'b1; mem.mem_rdata = 32'h5555AAAA;
        tick();
        tick();
        chk("stray idle rdata", rdata, 128'(32'hBBBB0002));
        chk("stray idle done", 128'(done), 128'(0));
        chk("stray idle mem_req", 128'(mem.mem_req), 128'(0));
        mem.mem_ack = 1'b0;
        tick();

        // Asynchronous reset in the middle of a vector load.
        start = 1'b1; we = 1'b0; vec = 1'b1; addr = 32'h300; mem.mem_ack = 1'b1;
        mem.mem_rdata = 32'h0;
        tick();  // c1 beat0
        start = 1'b0;
        mem.mem_rdata = 32'h10000001;
        tick();  // c2 beat1
        mem.mem_rdata = 32'h20000002;
        tick();  // c3 beat2 presented
        chk("rst pre mem_addr", 128'(mem.mem_addr), 128'(32'h308));
        chk("rst pre rdata", 128'(rdata[63:0]), 128'(64'h20000002_10000001));
        #2;
        rst = 1'b1;
        #1;
        chk("rst async mem_req", 128'(mem.mem_req), 128'(0));
        chk("rst async done", 128'(done), 128'(0));
        chk("rst async rdata", rdata, 128'(0));
        chk("rst async mem_addr", 128'(mem.mem_addr), 128'(0));
        chk("rst async mem_wdata", 128'(mem.mem_wdata), 128'(0));
        chk("rst async stall", 128'(stall), 128'(0));
        mem.mem_ack = 1'b0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst after state", 128'(state_dbg), 128'(S_IDLE));
        chk("rst after stall", 128'(stall), 128'(0));
        chk("rst after mem_req", 128'(mem.mem_req), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
